tkeo_mc: RTL

// - Multi-channel, time-multiplexed, k-lag Teager-Kaiser energy operator: psi[n-K] = x[n-K]^2 - x[n]*x[n-2K].
// - Replaces the single-channel, fixed-lag TKEO front end of the spike-detection chain.
// - Samples from N_CH electrodes arrive interleaved on one bus, tagged with a channel index.
// - Energy output is non-negative, scaled and clipped, and tagged with the same channel index.

---
 rtl/tkeo_mc.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/tkeo_mc.sv
// Multi-channel, time-multiplexed k-lag Teager-Kaiser energy operator with clipped, tagged output.
// Optional spike comparator enabled by defining TKEO_SPIKE_DET_EN.
module tkeo_mc #(
    parameter int DATA_W   = 16,
    parameter int N_CH     = 4,
    parameter int LAG_K    = 1,
    parameter int OUT_BITS = 29,
    parameter int SCALE_SH = 1,
    localparam int CH_W    = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    input  logic [CH_W-1:0]          in_ch,
    input  logic signed [DATA_W-1:0] data_in,
    output logic                     out_valid,
    output logic [CH_W-1:0]          out_ch,
    output logic [OUT_BITS-1:0]      data_out,
    output logic                     sat,
    output logic                     ch_err
`ifdef TKEO_SPIKE_DET_EN
   ,input  logic [OUT_BITS-1:0]      thresh
   ,output logic                     spike
`endif
);

    localparam int DEPTH  = 2*LAG_K + 1;
    // The incoming sample is the newest history entry, so only 2K older ones need storage.
    localparam int HIST   = 2*LAG_K;
    localparam int WARM_W = $clog2(DEPTH + 1);
    localparam int PW     = 2*DATA_W;

    logic signed [DATA_W-1:0] hist [N_CH][HIST];
    logic [WARM_W-1:0]        warm [N_CH];

    logic                     ch_ok;
    logic                     wr;
    logic signed [DATA_W-1:0] tap_k;
    logic signed [DATA_W-1:0] tap_2k;
    logic [WARM_W-1:0]        warm_cur;

    // stage 1: operand taps of the updated window
    logic                     v1;
    logic [CH_W-1:0]          ch1;
    logic signed [DATA_W-1:0] t0_q;
    logic signed [DATA_W-1:0] tk_q;
    logic signed [DATA_W-1:0] t2k_q;

    // stage 2: products
    logic                     v2;
    logic [CH_W-1:0]          ch2;
    logic signed [PW-1:0]     sq_q;
    logic signed [PW-1:0]     cr_q;

    // stage 3: difference
    logic                     v3;
    logic [CH_W-1:0]          ch3;
    logic signed [PW:0]       diff_q;

    logic signed [PW:0]       diff_sh;
    logic [PW:0]              e_val;
    logic                     ovf;
    logic [OUT_BITS-1:0]      e_clip;

    generate
        if (N_CH == (1 << CH_W)) begin : g_full_range
            assign ch_ok = 1'b1;
        end else begin : g_part_range
            assign ch_ok = (in_ch < CH_W'(N_CH));
        end
    endgenerate

    assign wr = in_valid & ch_ok;

    always_comb begin
        tap_k    = '0;
        tap_2k   = '0;
        warm_cur = '0;
        for (int c = 0; c < N_CH; c++) begin
            if (in_ch == CH_W'(c)) begin
                tap_k    = hist[c][LAG_K-1];
                tap_2k   = hist[c][HIST-1];
                warm_cur = warm[c];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < N_CH; c++) begin
                warm[c] <= '0;
                for (int i = 0; i < HIST; i++) begin
                    hist[c][i] <= '0;
                end
            end
        end else if (wr) begin
            for (int c = 0; c < N_CH; c++) begin
                if (in_ch == CH_W'(c)) begin
                    hist[c][0] <= data_in;
                    for (int i = 1; i < HIST; i++) begin
                        hist[c][i] <= hist[c][i-1];
                    end
                    if (warm[c] != WARM_W'(DEPTH)) begin
                        warm[c] <= warm[c] + 1'b1;
                    end
                end
            end
        end
    end

    // Taps come from the window as it will be after this write, so a back-to-back
    // beat on the same channel never sees stale history.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1     <= 1'b0;
            ch1    <= '0;
            t0_q   <= '0;
            tk_q   <= '0;
            t2k_q  <= '0;
            ch_err <= 1'b0;
        end else begin
            v1     <= wr && (warm_cur >= WARM_W'(DEPTH - 1));
            ch1    <= in_ch;
            t0_q   <= data_in;
            tk_q   <= tap_k;
            t2k_q  <= tap_2k;
            ch_err <= in_valid & ~ch_ok;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2   <= 1'b0;
            ch2  <= '0;
            sq_q <= '0;
            cr_q <= '0;
        end else begin
            v2   <= v1;
            ch2  <= ch1;
            sq_q <= PW'(tk_q) * PW'(tk_q);
            cr_q <= PW'(t0_q) * PW'(t2k_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v3     <= 1'b0;
            ch3    <= '0;
            diff_q <= '0;
        end else begin
            v3     <= v2;
            ch3    <= ch2;
            diff_q <= {sq_q[PW-1], sq_q} - {cr_q[PW-1], cr_q};
        end
    end

    always_comb begin
        diff_sh = diff_q >>> SCALE_SH;
        e_val   = diff_q[PW] ? '0 : diff_sh;
        ovf     = |e_val[PW:OUT_BITS];
        e_clip  = ovf ? '1 : e_val[OUT_BITS-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_ch    <= '0;
            data_out  <= '0;
            sat       <= 1'b0;
        end else begin
            out_valid <= v3;
            if (v3) begin
                out_ch   <= ch3;
                data_out <= e_clip;
                sat      <= ovf;
            end
        end
    end

`ifdef TKEO_SPIKE_DET_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            spike <= 1'b0;
        end else begin
            spike <= v3 && (e_clip > thresh);
        end
    end
`endif

endmodule
